// File: rtl/chip8_xfer_if.sv
// chip8_xfer_if: CPU/register-file/memory side bundle of the transfer engine
// master: decoder + register file + memory port (drives requests, read data, acks)
// slave:  transfer engine (drives status, register/memory strobes, addresses, I update)
interface chip8_xfer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int NREGS  = 16
);
    localparam int IDX_W = $clog2(NREGS);
    logic              start;
    logic [1:0]        op;
    logic [IDX_W-1:0]  x_idx;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic [IDX_W-1:0]  reg_rd_idx;
    logic [DATA_W-1:0] reg_rd_data;
    logic              reg_wr_en;
    logic [IDX_W-1:0]  reg_wr_idx;
    logic [DATA_W-1:0] reg_wr_data;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_read_idx;
    logic [DATA_W-1:0] mem_read_byte;
    logic              mem_read_ack;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_write_idx;
    logic [DATA_W-1:0] mem_write_byte;
    logic              i_update;
    logic [ADDR_W-1:0] i_next;
    modport master (
        output start, op, x_idx, base_addr, reg_rd_data, mem_read_byte, mem_read_ack,
        input  busy, done, err, reg_rd_idx, reg_wr_en, reg_wr_idx, reg_wr_data,
               mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
               i_update, i_next
    );
    modport slave (
        input  start, op, x_idx, base_addr, reg_rd_data, mem_read_byte, mem_read_ack,
        output busy, done, err, reg_rd_idx, reg_wr_en, reg_wr_idx, reg_wr_data,
               mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
               i_update, i_next
    );
endinterface

// File: rtl/chip8_xfer_engine.sv
// chip8_xfer_engine: multi-cycle Fx55 store, Fx65 load and Fx33 BCD transfers
// clk, rst_n (async active-low); bus (slave): start/op/x_idx/base_addr request,
// busy/done/err status, register file read/write port, memory read/write port, i_update/i_next
module chip8_xfer_engine #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    parameter int INC_I  = 0
) (
    input logic clk,
    input logic rst_n,
    chip8_xfer_if.slave bus
);
    localparam int IDX_W = $clog2(NREGS);
    typedef enum logic [2:0] {IDLE, STORE, LOAD_REQ, LOAD_WAIT, BCD_H, BCD_T, BCD_O, DONE} state_t;
    state_t state;
    logic [1:0] op_l;
    logic [IDX_W-1:0] x_l, k;
    logic [ADDR_W-1:0] base_l, i_next_q, addr;
    logic [DATA_W-1:0] v;
    logic err_q, bad, last;
    assign bad  = bus.op == 2'd3 || (bus.op == 2'd2 && DATA_W != 8);
    assign last = k == x_l;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_l     <= '0;
            x_l      <= '0;
            k        <= '0;
            base_l   <= '0;
            v        <= '0;
            err_q    <= 1'b0;
            i_next_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    if (bad) err_q <= 1'b1;
                    else begin
                        op_l     <= bus.op;
                        x_l      <= bus.x_idx;
                        base_l   <= bus.base_addr;
                        k        <= '0;
                        i_next_q <= bus.base_addr + ADDR_W'(bus.x_idx) + ADDR_W'(1);
                        state    <= bus.op == 2'd0 ? STORE : bus.op == 2'd1 ? LOAD_REQ : BCD_H;
                    end
                end
                STORE: if (last) state <= DONE; else k <= k + 1'b1;
                LOAD_REQ: state <= LOAD_WAIT;
                LOAD_WAIT: if (bus.mem_read_ack) begin
                    if (last) state <= DONE;
                    else begin
                        k     <= k + 1'b1;
                        state <= LOAD_REQ;
                    end
                end
                // the hundreds digit is taken straight from the read port; later digits use the latched copy
                BCD_H: begin
                    v     <= bus.reg_rd_data;
                    state <= BCD_T;
                end
                BCD_T: state <= BCD_O;
                BCD_O: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
    assign addr = base_l + (state == BCD_T ? ADDR_W'(1) : state == BCD_O ? ADDR_W'(2) : ADDR_W'(k));
    assign bus.busy           = state != IDLE;
    assign bus.done           = state == DONE;
    assign bus.err            = err_q;
    assign bus.i_update       = INC_I != 0 && state == DONE && op_l != 2'd2;
    assign bus.i_next         = i_next_q;
    assign bus.reg_rd_idx     = state == BCD_H ? x_l : k;
    assign bus.reg_wr_en      = state == LOAD_WAIT && bus.mem_read_ack;
    assign bus.reg_wr_idx     = k;
    assign bus.reg_wr_data    = bus.reg_wr_en ? bus.mem_read_byte : '0;
    assign bus.mem_read       = state == LOAD_REQ;
    assign bus.mem_read_idx   = addr;
    assign bus.mem_write      = state inside {STORE, BCD_H, BCD_T, BCD_O};
    assign bus.mem_write_idx  = addr;
    assign bus.mem_write_byte = state == STORE ? bus.reg_rd_data :
                                state == BCD_H ? bus.reg_rd_data / DATA_W'(100) :
                                state == BCD_T ? (v / DATA_W'(10)) % DATA_W'(10) :
                                state == BCD_O ? v % DATA_W'(10) : '0;
endmodule

// File: tb/tb_chip8_xfer_engine.sv
// tb_chip8_xfer_engine: directed checks of store/load/BCD transfers, I update, errors and reset abort
module tb_chip8_xfer_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chip8_xfer_if #(.ADDR_W(12), .DATA_W(8), .NREGS(16)) b0();
    chip8_xfer_if #(.ADDR_W(12), .DATA_W(8), .NREGS(16)) b1();
    chip8_xfer_engine #(.ADDR_W(12), .DATA_W(8), .NREGS(16), .INC_I(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    chip8_xfer_engine #(.ADDR_W(12), .DATA_W(8), .NREGS(16), .INC_I(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    logic [7:0] regs [16];
    logic [7:0] mem [4096];
    int cyc = 0, tests = 0, fails = 0, t0 = 0;
    int wcnt = 0, rcnt = 0, regw = 0, both = 0, iup0 = 0, wlast = 0;
    int lat_cfg = 1, cnt = 0;
    logic ack_r = 1'b0, force_ack = 1'b0;
    logic [11:0] raddr = '0;

    assign b0.reg_rd_data   = regs[b0.reg_rd_idx];
    assign b0.mem_read_ack  = ack_r | force_ack;
    assign b0.mem_read_byte = ack_r ? mem[raddr] : 8'h00;
    assign b1.reg_rd_data   = regs[b1.reg_rd_idx];
    assign b1.mem_read_ack  = 1'b0;
    assign b1.mem_read_byte = 8'h00;

    // memory with a configurable read latency, register file and activity counters for dut 0
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ack_r <= 1'b0;
        if (b0.mem_read) begin
            raddr <= b0.mem_read_idx;
            rcnt  <= rcnt + 1;
            if (lat_cfg == 1) ack_r <= 1'b1; else cnt <= lat_cfg - 1;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) ack_r <= 1'b1;
        end
        if (b0.mem_write) begin
            mem[b0.mem_write_idx] <= b0.mem_write_byte;
            wcnt  <= wcnt + 1;
            wlast <= cyc;
        end
        if (b0.reg_wr_en) begin
            regs[b0.reg_wr_idx] <= b0.reg_wr_data;
            regw <= regw + 1;
        end
        if (b0.mem_read && b0.mem_write) both <= both + 1;
        if (b0.i_update) iup0 <= iup0 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [1:0] op, input logic [3:0] x, input logic [11:0] base);
        @(posedge clk); #1;
        b0.start = 1'b1; b0.op = op; b0.x_idx = x; b0.base_addr = base;
        t0 = cyc;
        @(posedge clk); #1;
        b0.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (b0.done) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    int lat, w0, r0, g0;
    logic iu;
    logic [11:0] inx;

    initial begin
        b0.start = 1'b0; b0.op = '0; b0.x_idx = '0; b0.base_addr = '0;
        b1.start = 1'b0; b1.op = '0; b1.x_idx = '0; b1.base_addr = '0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_status", {29'd0, b0.busy, b0.done, b0.err}, 32'd0);
        chk("reset_strobes", {28'd0, b0.mem_read, b0.mem_write, b0.reg_wr_en, b0.i_update}, 32'd0);
        chk("reset_addr", {8'd0, b0.mem_write_idx, b0.i_next}, 32'd0);
        rst_n = 1'b1;

        regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
        w0 = wcnt; g0 = regw;
        go(2'd0, 4'd3, 12'h300);
        wait_done(lat);
        chk("store_latency", lat, 5);
        chk("store_mem", {mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]}, 32'h11223344);
        chk("store_wr_count", wcnt - w0, 4);
        chk("store_last_wr_cycle", wlast - t0, 4);
        chk("store_no_reg_wr", regw - g0, 0);

        regs[0] = 8'h00; regs[1] = 8'h00; regs[2] = 8'h00;
        mem[12'hFFF] = 8'hAA; mem[12'h000] = 8'hBB; mem[12'h001] = 8'hCC;
        lat_cfg = 3; r0 = rcnt; w0 = wcnt;
        go(2'd1, 4'd2, 12'hFFF);
        wait_done(lat);
        chk("load_latency", lat, 13);
        @(negedge clk);
        chk("load_regs", {8'd0, regs[0], regs[1], regs[2]}, 32'h00AABBCC);
        chk("load_rd_count", rcnt - r0, 3);
        chk("load_no_mem_wr", wcnt - w0, 0);

        regs[5] = 8'hFE;
        go(2'd2, 4'd5, 12'h400);
        wait_done(lat);
        chk("bcd_latency", lat, 4);
        @(negedge clk);
        chk("bcd_254", {8'd0, mem[12'h400], mem[12'h401], mem[12'h402]}, 32'h00020504);
        regs[0] = 8'h00;
        mem[12'h410] = 8'hFF; mem[12'h411] = 8'hFF; mem[12'h412] = 8'hFF;
        go(2'd2, 4'd0, 12'h410);
        wait_done(lat);
        @(negedge clk);
        chk("bcd_zero", {8'd0, mem[12'h410], mem[12'h411], mem[12'h412]}, 32'h00000000);

        @(posedge clk); #1;
        b1.start = 1'b1; b1.op = 2'd0; b1.x_idx = 4'd15; b1.base_addr = 12'h200;
        t0 = cyc;
        @(posedge clk); #1;
        b1.start = 1'b0;
        lat = -1; iu = 1'b0; inx = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (b1.done) begin
                lat = cyc - t0; iu = b1.i_update; inx = b1.i_next;
                break;
            end
        end
        chk("inc_latency", lat, 17);
        chk("inc_i_update", {31'd0, iu}, 32'd1);
        chk("inc_i_next", {20'd0, inx}, 32'h210);
        @(negedge clk);
        chk("inc_i_update_drop", {31'd0, b1.i_update}, 32'd0);

        w0 = wcnt; r0 = rcnt;
        go(2'd3, 4'd2, 12'h700);
        @(negedge clk);
        chk("illegal_err", {30'd0, b0.err, b0.busy}, 32'd2);
        @(negedge clk);
        chk("illegal_err_pulse", {30'd0, b0.err, b0.busy}, 32'd0);
        chk("illegal_no_mem", (wcnt - w0) + (rcnt - r0), 0);

        regs[0] = 8'h05; regs[1] = 8'h06; mem[12'h600] = 8'h00;
        w0 = wcnt; r0 = rcnt; g0 = regw;
        go(2'd0, 4'd1, 12'h500);
        b0.start = 1'b1; b0.op = 2'd1; b0.x_idx = 4'd3; b0.base_addr = 12'h600;
        @(posedge clk); #1;
        b0.start = 1'b0;
        wait_done(lat);
        chk("busy_start_latency", lat, 3);
        @(negedge clk);
        chk("busy_start_mem", {16'd0, mem[12'h500], mem[12'h501]}, 32'h0506);
        chk("busy_start_ignored", (rcnt - r0) + (regw - g0) + (wcnt - w0), 2);
        @(negedge clk);
        chk("busy_start_idle", {31'd0, b0.busy}, 32'd0);

        g0 = regw;
        @(posedge clk); #1 force_ack = 1'b1;
        @(posedge clk); #1 force_ack = 1'b0;
        @(negedge clk);
        chk("spurious_ack", regw - g0, 0);

        regs[0] = 8'h77; mem[12'h010] = 8'h99; lat_cfg = 5; g0 = regw;
        go(2'd1, 4'd0, 12'h010);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wait", {30'd0, b0.busy, b0.mem_read}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {26'd0, b0.busy, b0.done, b0.err, b0.mem_read, b0.mem_write, b0.reg_wr_en}, 32'd0);
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        chk("abort_no_reg_wr", {regw - g0}, 0);
        chk("abort_reg_kept", {24'd0, regs[0]}, 32'h77);

        mem[12'h011] = 8'h5A; lat_cfg = 1;
        go(2'd1, 4'd0, 12'h011);
        wait_done(lat);
        chk("fresh_load_latency", lat, 3);
        @(negedge clk);
        chk("fresh_load_reg", {24'd0, regs[0]}, 32'h5A);

        chk("no_rd_wr_overlap", both, 0);
        chk("no_i_update_inc0", iup0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/chip8_xfer_engine.md
Name: chip8_xfer_engine

Overview:
- Parametrised successor to the CPU's inline register/memory transfer logic; executes multi-cycle Fx55 (store V0..Vx), Fx65 (load V0..Vx) and Fx33 (BCD) operations.
- The CPU decoder issues a one-cycle start and stalls on busy.
- The block drives the shared memory port and the V register file, and optionally reports an updated I (original COSMAC quirk).
- Generalised in address width, data width, register count, memory read latency and I-increment mode.

Parameters:
- ADDR_W, 12, memory address width; all address arithmetic wraps mod 2^ADDR_W.
- DATA_W, 8, register/memory byte width; BCD op requires DATA_W == 8.
- NREGS, 16, number of V registers; IDX_W = clog2(NREGS).
- INC_I, 0, 1 = after STORE/LOAD, report I + x + 1 on i_next with i_update pulse.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only when busy = 0
- op  in  2  0 = STORE, 1 = LOAD, 2 = BCD, 3 = illegal
- x_idx  in  IDX_W  last register index (STORE/LOAD) or source register (BCD)
- base_addr  in  ADDR_W  value of I at start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on illegal op (op = 3, or BCD with DATA_W != 8)
- reg_rd_idx  out  IDX_W  register file read index; reg_rd_data is combinational
- reg_rd_data  in  DATA_W  register file read data
- reg_wr_en  out  1  register write strobe
- reg_wr_idx  out  IDX_W  register write index
- reg_wr_data  out  DATA_W  register write data
- mem_read  out  1  one-cycle read request
- mem_read_idx  out  ADDR_W  read address, valid with mem_read
- mem_read_byte  in  DATA_W  read data, valid with mem_read_ack
- mem_read_ack  in  1  read completion; arrives 1 or more cycles after mem_read
- mem_write  out  1  one-cycle write strobe
- mem_write_idx  out  ADDR_W  write address
- mem_write_byte  out  DATA_W  write data
- i_update  out  1  one-cycle strobe with done when INC_I = 1 and op is STORE/LOAD
- i_next  out  ADDR_W  base_addr + x_idx + 1, mod 2^ADDR_W

Behaviour:
- Reset: state IDLE; all outputs 0; counter and latched address/index 0. Reset asserted mid-operation aborts at once; no further memory or register writes occur.
- IDLE + start: latch op, x_idx, base_addr; counter k = 0.
  - STORE goes to STORE.
  - LOAD goes to LOAD_REQ.
  - BCD goes to BCD_H.
  - Illegal op: err pulses next cycle, busy stays 0, no transfers.
- start while busy: ignored entirely.
- Ordering is ascending: k = 0..x, address = base + k (wrapping).
- STORE: one byte per cycle. reg_rd_idx = k; mem_write = 1, idx = base + k, byte = reg_rd_data.
  - If k == x, go to DONE; else k++.
  - Total x + 1 cycles.
- LOAD_REQ: mem_read = 1 for exactly one cycle, idx = base + k; then LOAD_WAIT.
- LOAD_WAIT: hold with no outputs until mem_read_ack. On ack: reg_wr_en = 1, idx k, data = mem_read_byte (same cycle, combinational).
  - If k == x, go to DONE; else k++ and return to LOAD_REQ.
  - A spurious ack outside LOAD_WAIT is ignored.
- BCD: latch v = reg[x] on entry.
  - BCD_H writes v/100 at base.
  - BCD_T writes (v/10)%10 at base+1.
  - BCD_O writes v%10 at base+2.
  - One write per cycle, then DONE.
- DONE: done = 1 and busy = 1 for one cycle; i_update per INC_I; then IDLE. A start in the DONE cycle is ignored; the next start is accepted in IDLE.
- Never asserts mem_read and mem_write in the same cycle.
- Latency:
  - STORE: x + 2 cycles from start to done.
  - LOAD with read latency L: (x + 1)(L + 1) + 1 cycles.
  - BCD: 4 cycles.

Test Plan:
- STORE x=3, base=0x300, V0..V3 = 11,22,33,44 -> writes [300..303] = 11,22,33,44 on consecutive cycles; done 5 cycles after start; no register writes.
- LOAD x=2, base=0xFFF, mem[FFF]=AA, mem[000]=BB, mem[001]=CC, ack latency 3 -> V0=AA, V1=BB, V2=CC (address wraps); done at cycle 13; mem_read pulses exactly 3 times.
- BCD with V5=0xFE (254), base=0x400 -> [400]=2, [401]=5, [402]=4; done 4 cycles after start; V0=0 -> 0,0,0.
- INC_I=1, STORE x=15, base=0x200 -> i_update with done, i_next=0x210; INC_I=0 -> i_update never asserts.
- op=3 -> err pulse, busy stays 0, no memory activity. start during busy -> ignored, original op completes unchanged.
- rst_n low during LOAD_WAIT, with ack arriving afterwards -> no register write; outputs 0; a fresh start works normally.
